// File: rtl/uart_alu_interface.sv
// Sequencer between the UART RX/TX pair and the combinational ALU: collects
// operand A, operand B and opcode bytes, captures the ALU result and ships it out.
//
// state    | meaning
// ---------+------------------------------------------------------------
// WAIT_A   | idle, waiting for operand A byte (no timeout)
// WAIT_B   | operand A latched, waiting for operand B (timeout armed)
// WAIT_OP  | operands latched, waiting for opcode byte (timeout armed)
// EXEC     | one cycle for the ALU to settle, result captured on exit
// SEND     | o_tx_start pulse, transmitter launched
// WAIT_TX  | waiting for the transmitter stop bit to finish
module uart_alu_interface #(
    parameter int DBIT         = 8,
    parameter int NB_OP        = 6,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_rx_done,
    input  logic [DBIT-1:0]  i_rx_data,
    input  logic [DBIT-1:0]  i_alu_result,
    input  logic             i_tx_done,
    output logic [DBIT-1:0]  o_op_a,
    output logic [DBIT-1:0]  o_op_b,
    output logic [NB_OP-1:0] o_opcode,
    output logic             o_tx_start,
    output logic [DBIT-1:0]  o_tx_data,
    output logic             o_busy,
    output logic             o_timeout,
    output logic             o_overrun
);

    typedef enum logic [2:0] {
        WAIT_A  = 3'd0,
        WAIT_B  = 3'd1,
        WAIT_OP = 3'd2,
        EXEC    = 3'd3,
        SEND    = 3'd4,
        WAIT_TX = 3'd5
    } state_t;

    localparam logic [TIMEOUT_BITS-1:0] CNT_MAX = '1;
    localparam logic [TIMEOUT_BITS-1:0] CNT_ONE = {{(TIMEOUT_BITS-1){1'b0}}, 1'b1};

    state_t                  state_q, state_d;
    logic [TIMEOUT_BITS-1:0] cnt_q, cnt_d;
    logic [DBIT-1:0]         op_a_d, op_b_d, tx_data_d;
    logic [NB_OP-1:0]        opcode_d;
    logic                    timeout_d, overrun_d;
    logic                    busy_d, tx_start_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_a_d    = o_op_a;
        op_b_d    = o_op_b;
        opcode_d  = o_opcode;
        tx_data_d = o_tx_data;
        timeout_d = 1'b0;
        overrun_d = o_overrun;

        case (state_q)
            WAIT_A: begin
                cnt_d = '0;
                if (i_rx_done) begin
                    op_a_d  = i_rx_data;
                    state_d = WAIT_B;
                end
            end
            WAIT_B: begin
                // An accepted byte wins over a timeout landing on the same cycle.
                if (i_rx_done) begin
                    op_b_d  = i_rx_data;
                    cnt_d   = '0;
                    state_d = WAIT_OP;
                end else if (cnt_q == CNT_MAX) begin
                    cnt_d     = '0;
                    timeout_d = 1'b1;
                    state_d   = WAIT_A;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            WAIT_OP: begin
                if (i_rx_done) begin
                    opcode_d = i_rx_data[NB_OP-1:0];
                    cnt_d    = '0;
                    state_d  = EXEC;
                end else if (cnt_q == CNT_MAX) begin
                    cnt_d     = '0;
                    timeout_d = 1'b1;
                    state_d   = WAIT_A;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            EXEC: begin
                tx_data_d = i_alu_result;
                state_d   = SEND;
            end
            SEND: begin
                state_d = WAIT_TX;
            end
            WAIT_TX: begin
                if (i_tx_done) begin
                    state_d = WAIT_A;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = WAIT_A;
            end
        endcase

        if (i_rx_done && (state_q == EXEC || state_q == SEND || state_q == WAIT_TX)) begin
            overrun_d = 1'b1;
        end

        // Status outputs are registered from the next state so they track it exactly.
        busy_d     = (state_d == EXEC) || (state_d == SEND) || (state_d == WAIT_TX);
        tx_start_d = (state_d == SEND);
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q    <= WAIT_A;
            cnt_q      <= '0;
            o_op_a     <= '0;
            o_op_b     <= '0;
            o_opcode   <= '0;
            o_tx_data  <= '0;
            o_tx_start <= 1'b0;
            o_busy     <= 1'b0;
            o_timeout  <= 1'b0;
            o_overrun  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            o_op_a     <= op_a_d;
            o_op_b     <= op_b_d;
            o_opcode   <= opcode_d;
            o_tx_data  <= tx_data_d;
            o_tx_start <= tx_start_d;
            o_busy     <= busy_d;
            o_timeout  <= timeout_d;
            o_overrun  <= overrun_d;
        end
    end

endmodule

// File: tb/tb_uart_alu_interface.sv
// Directed plus randomized frames against a byte-level reference model; the
// timeout counter is shrunk so stall scenarios stay short.
module tb_uart_alu_interface;

    localparam int TB_TO   = 5;
    localparam int TO_CYC  = 1 << TB_TO;

    logic       i_clk, i_reset, i_rx_done, i_tx_done;
    logic [7:0] i_rx_data, i_alu_result;
    logic [7:0] o_op_a, o_op_b, o_tx_data;
    logic [5:0] o_opcode;
    logic       o_tx_start, o_busy, o_timeout, o_overrun;

    int n_err = 0;
    int n_checks = 0;

    logic [7:0] exp_a, exp_b, exp_tx;
    logic [5:0] exp_op;
    logic       exp_ovr;

    uart_alu_interface #(.DBIT(8), .NB_OP(6), .TIMEOUT_BITS(TB_TO)) dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_rx_done    (i_rx_done),
        .i_rx_data    (i_rx_data),
        .i_alu_result (i_alu_result),
        .i_tx_done    (i_tx_done),
        .o_op_a       (o_op_a),
        .o_op_b       (o_op_b),
        .o_opcode     (o_opcode),
        .o_tx_start   (o_tx_start),
        .o_tx_data    (o_tx_data),
        .o_busy       (o_busy),
        .o_timeout    (o_timeout),
        .o_overrun    (o_overrun)
    );

    function automatic logic [7:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                           input logic [5:0] op);
        case (op)
            6'h20:   return a + b;
            6'h22:   return a - b;
            6'h24:   return a & b;
            6'h25:   return a | b;
            6'h26:   return a ^ b;
            6'h27:   return ~(a | b);
            6'h02:   return a >> b[2:0];
            default: return a ^ b;
        endcase
    endfunction

    // ALU stub driven from what the DUT presents
    assign i_alu_result = alu_ref(o_op_a, o_op_b, o_opcode);

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_operands(input string tag);
        check({tag, "_op_a"}, {24'd0, o_op_a}, {24'd0, exp_a});
        check({tag, "_op_b"}, {24'd0, o_op_b}, {24'd0, exp_b});
        check({tag, "_opcode"}, {26'd0, o_opcode}, {26'd0, exp_op});
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge i_clk);
        i_rx_data = b;
        i_rx_done = 1'b1;
        @(negedge i_clk);
        i_rx_done = 1'b0;
        i_rx_data = 8'($urandom);
    endtask

    task automatic pulse_tx_done();
        @(negedge i_clk);
        i_tx_done = 1'b1;
        @(negedge i_clk);
        i_tx_done = 1'b0;
    endtask

    // Called right after the opcode byte has been accepted.
    task automatic finish_frame(input string tag, input int hold);
        check({tag, "_exec_start"}, {31'd0, o_tx_start}, 32'd0);
        check({tag, "_exec_busy"}, {31'd0, o_busy}, 32'd1);
        @(negedge i_clk);
        check({tag, "_start"}, {31'd0, o_tx_start}, 32'd1);
        check({tag, "_tx_data"}, {24'd0, o_tx_data}, {24'd0, exp_tx});
        @(negedge i_clk);
        check({tag, "_start_1pulse"}, {31'd0, o_tx_start}, 32'd0);
        repeat (hold) @(negedge i_clk);
        check({tag, "_wait_busy"}, {31'd0, o_busy}, 32'd1);
        pulse_tx_done();
        check({tag, "_idle_busy"}, {31'd0, o_busy}, 32'd0);
        check({tag, "_overrun"}, {31'd0, o_overrun}, {31'd0, exp_ovr});
    endtask

    task automatic do_frame(input string tag, input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] opbyte, input int gap, input int hold);
        send_byte(a);
        repeat (gap) @(negedge i_clk);
        send_byte(b);
        repeat (gap) @(negedge i_clk);
        send_byte(opbyte);
        exp_a  = a;
        exp_b  = b;
        exp_op = opbyte[5:0];
        exp_tx = alu_ref(exp_a, exp_b, exp_op);
        check_operands(tag);
        finish_frame(tag, hold);
    endtask

    initial begin
        int cnt;
        logic seen;
        logic [5:0] op_tab [7];
        logic [7:0] ra, rb, rop;
        logic [1:0] hi;

        op_tab = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h02};
        i_reset = 1'b0; i_rx_done = 1'b0; i_tx_done = 1'b0; i_rx_data = 8'h00;
        exp_a = 0; exp_b = 0; exp_op = 0; exp_tx = 0; exp_ovr = 0;

        #3;
        check_operands("reset");
        check("reset_tx_data", {24'd0, o_tx_data}, 32'd0);
        check("reset_outs", {28'd0, o_tx_start, o_busy, o_timeout, o_overrun}, 32'd0);
        @(negedge i_clk);
        i_reset = 1'b1;

        // basic frame and opcode truncation
        do_frame("basic", 8'h05, 8'h03, 8'h20, 0, 3);
        check("basic_result", {24'd0, o_tx_data}, 32'h08);
        do_frame("trunc", 8'h0F, 8'h30, 8'hE5, 1, 0);
        check("trunc_opcode", {26'd0, o_opcode}, 32'h25);

        // tx_done outside WAIT_TX is ignored
        pulse_tx_done();
        check("txdone_idle_busy", {31'd0, o_busy}, 32'd0);
        send_byte(8'h41);
        pulse_tx_done();
        send_byte(8'h12);
        send_byte(8'h26);
        exp_a = 8'h41; exp_b = 8'h12; exp_op = 6'h26; exp_tx = alu_ref(exp_a, exp_b, exp_op);
        check_operands("txdone_wait_b");
        finish_frame("txdone_wait_b", 1);

        // timeout in WAIT_B
        send_byte(8'h11);
        cnt = 0; seen = 1'b0;
        while (!seen && cnt < 4 * TO_CYC) begin
            @(negedge i_clk);
            cnt++;
            seen = o_timeout;
        end
        check("to_b_seen", {31'd0, seen}, 32'd1);
        check("to_b_cycles", cnt, TO_CYC);
        @(negedge i_clk);
        check("to_b_1pulse", {31'd0, o_timeout}, 32'd0);
        exp_a = 8'h11;
        check_operands("to_b_kept");
        do_frame("after_to", 8'h02, 8'h04, 8'h20, 0, 0);
        check("after_to_result", {24'd0, o_tx_data}, 32'h06);

        // timeout in WAIT_OP keeps both operands
        send_byte(8'h33);
        send_byte(8'h44);
        repeat (TO_CYC) @(negedge i_clk);
        check("to_op_pulse", {31'd0, o_timeout}, 32'd1);
        exp_a = 8'h33; exp_b = 8'h44;
        check_operands("to_op_kept");
        check("to_op_busy", {31'd0, o_busy}, 32'd0);

        // byte on the exact timeout cycle is accepted
        send_byte(8'hA1);
        repeat (TO_CYC - 2) @(negedge i_clk);
        send_byte(8'hB2);
        check("edge_no_to", {31'd0, o_timeout}, 32'd0);
        check("edge_op_b", {24'd0, o_op_b}, 32'hB2);
        repeat (TO_CYC - 2) @(negedge i_clk);
        send_byte(8'h24);
        check("edge_no_to_op", {31'd0, o_timeout}, 32'd0);
        exp_a = 8'hA1; exp_b = 8'hB2; exp_op = 6'h24; exp_tx = alu_ref(exp_a, exp_b, exp_op);
        check_operands("edge");
        finish_frame("edge", 0);

        // one cycle too late: timeout fires, byte restarts the frame as operand A
        send_byte(8'h5A);
        repeat (TO_CYC) @(negedge i_clk);
        check("late_to", {31'd0, o_timeout}, 32'd1);
        send_byte(8'hC3);
        check("late_op_a", {24'd0, o_op_a}, 32'hC3);
        send_byte(8'h0E);
        send_byte(8'h22);
        exp_a = 8'hC3; exp_b = 8'h0E; exp_op = 6'h22; exp_tx = alu_ref(exp_a, exp_b, exp_op);
        check_operands("late");
        finish_frame("late", 2);

        // overrun during WAIT_TX
        send_byte(8'h09);
        send_byte(8'h06);
        send_byte(8'h25);
        exp_a = 8'h09; exp_b = 8'h06; exp_op = 6'h25; exp_tx = alu_ref(exp_a, exp_b, exp_op);
        @(negedge i_clk);
        @(negedge i_clk);
        send_byte(8'h77);
        exp_ovr = 1'b1;
        check("ovr_flag", {31'd0, o_overrun}, 32'd1);
        check_operands("ovr_kept");
        check("ovr_tx_data", {24'd0, o_tx_data}, {24'd0, exp_tx});
        pulse_tx_done();
        check("ovr_idle", {31'd0, o_busy}, 32'd0);
        do_frame("ovr_sticky", 8'h10, 8'h01, 8'h22, 0, 1);

        // randomized frames
        for (int i = 0; i < 8; i++) begin
            ra  = 8'($urandom);
            rb  = 8'($urandom);
            hi  = 2'($urandom_range(0, 3));
            rop = {hi, op_tab[$urandom_range(0, 6)]};
            do_frame("rand", ra, rb, rop, $urandom_range(0, 3), $urandom_range(0, 4));
        end

        // asynchronous reset while in WAIT_TX
        send_byte(8'hF0);
        send_byte(8'h0F);
        send_byte(8'h20);
        @(negedge i_clk);
        @(negedge i_clk);
        check("rst_pre_busy", {31'd0, o_busy}, 32'd1);
        #2 i_reset = 1'b0;
        #1;
        exp_a = 0; exp_b = 0; exp_op = 0; exp_tx = 0; exp_ovr = 0;
        check_operands("rst_async");
        check("rst_tx_data", {24'd0, o_tx_data}, 32'd0);
        check("rst_outs", {28'd0, o_tx_start, o_busy, o_timeout, o_overrun}, 32'd0);
        @(negedge i_clk);
        i_reset = 1'b1;
        seen = 1'b0;
        repeat (4) begin
            @(negedge i_clk);
            seen = seen | o_tx_start | o_busy;
        end
        pulse_tx_done();
        seen = seen | o_tx_start | o_busy;
        check("rst_no_start", {31'd0, seen}, 32'd0);
        do_frame("post_rst", 8'h07, 8'h02, 8'h22, 0, 0);
        check("post_rst_result", {24'd0, o_tx_data}, 32'h05);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
